clk_period_meter: RTL and testbench

Measures an incoming baud or divided clock against the system clock and reports its period, high time and low time in system-clock cycles. It recovers the division ratio that a clock divider was programmed with. It sits on the receive or monitor side of a divided-clock link, for baud-rate auto-detection and divider self-check. Results are published with a one-cycle valid strobe; a missing or stalled input clock is flagged with a timeout.

---
 rtl/clk_period_meter_if.sv | 40 ++++
 rtl/clk_period_meter.sv | 158 +++++++++++++++
 tb/tb_clk_period_meter.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/clk_period_meter_if.sv
`default_nettype none
// ============================================================================
// clk_period_meter_if : control and result bundle of the clock period meter
// Revision 1.0
// ============================================================================
interface clk_period_meter_if #(
  parameter int divisor_width = 16
);
  logic                     EN;
  logic                     BCLK_in;
  logic [divisor_width-1:0] Period;
  logic [divisor_width-1:0] High_Time;
  logic [divisor_width-1:0] Low_Time;
  logic                     Valid;
  logic                     Timeout;
  logic                     Busy;

  modport master (
    output EN,
    output BCLK_in,
    input  Period,
    input  High_Time,
    input  Low_Time,
    input  Valid,
    input  Timeout,
    input  Busy
  );

  modport slave (
    input  EN,
    input  BCLK_in,
    output Period,
    output High_Time,
    output Low_Time,
    output Valid,
    output Timeout,
    output Busy
  );
endinterface
`default_nettype wire

// File: rtl/clk_period_meter.sv
`default_nettype none
// ============================================================================
// clk_period_meter : measures period / high / low time of an async clock
// Revision 1.0
// ============================================================================
module clk_period_meter #(
  parameter int divisor_width = 16,
  parameter int SYNC_STAGES   = 2
) (
  input wire clk,
  input wire rst_n,
  clk_period_meter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_RISE  = 2'd1,
    MEASURE_HI = 2'd2,
    MEASURE_LO = 2'd3
  } state_t;

  localparam logic [divisor_width-1:0] COUNT_MAX = {divisor_width{1'b1}};
  localparam logic [divisor_width-1:0] COUNT_ONE = {{(divisor_width-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0]   sync_q;
  logic                     bclk_prev;
  logic                     bclk_sync;
  logic                     rise;
  logic                     fall;

  state_t                   state;
  state_t                   state_nx;
  logic [divisor_width-1:0] count;
  logic [divisor_width-1:0] count_nx;
  logic [divisor_width-1:0] count_inc;
  logic [divisor_width-1:0] hi_cnt;
  logic [divisor_width-1:0] hi_cnt_nx;
  logic [divisor_width-1:0] period_q;
  logic [divisor_width-1:0] period_nx;
  logic [divisor_width-1:0] high_q;
  logic [divisor_width-1:0] high_nx;
  logic [divisor_width-1:0] low_q;
  logic [divisor_width-1:0] low_nx;
  logic                     valid_q;
  logic                     valid_nx;
  logic                     timeout_q;
  logic                     timeout_nx;

  // Synchronizer and edge detector run regardless of EN so a level is ready on enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      bclk_prev <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], bus.BCLK_in};
      bclk_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  assign bclk_sync = sync_q[SYNC_STAGES-1];
  assign rise      = bclk_sync & ~bclk_prev;
  assign fall      = ~bclk_sync & bclk_prev;
  assign count_inc = (count == COUNT_MAX) ? count : count + COUNT_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      hi_cnt    <= '0;
      period_q  <= '0;
      high_q    <= '0;
      low_q     <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nx;
      count     <= count_nx;
      hi_cnt    <= hi_cnt_nx;
      period_q  <= period_nx;
      high_q    <= high_nx;
      low_q     <= low_nx;
      valid_q   <= valid_nx;
      timeout_q <= timeout_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    count_nx   = count;
    hi_cnt_nx  = hi_cnt;
    period_nx  = period_q;
    high_nx    = high_q;
    low_nx     = low_q;
    valid_nx   = 1'b0;
    timeout_nx = timeout_q;

    if (!bus.EN) begin
      state_nx   = IDLE;
      count_nx   = '0;
      timeout_nx = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state_nx = WAIT_RISE;
          count_nx = '0;
        end
        WAIT_RISE: begin
          if (rise) begin
            state_nx = MEASURE_HI;
            count_nx = COUNT_ONE;
          end
        end
        MEASURE_HI: begin
          if (fall) begin
            hi_cnt_nx = count;
            count_nx  = count_inc;
            state_nx  = MEASURE_LO;
          end else if (count == COUNT_MAX) begin
            timeout_nx = 1'b1;
            state_nx   = WAIT_RISE;
          end else begin
            count_nx = count_inc;
          end
        end
        MEASURE_LO: begin
          // A closing rise on the terminal count still completes the measurement
          if (rise) begin
            period_nx  = count;
            high_nx    = hi_cnt;
            low_nx     = count - hi_cnt;
            valid_nx   = 1'b1;
            timeout_nx = 1'b0;
            count_nx   = COUNT_ONE;
            state_nx   = MEASURE_HI;
          end else if (count == COUNT_MAX) begin
            timeout_nx = 1'b1;
            state_nx   = WAIT_RISE;
          end else begin
            count_nx = count_inc;
          end
        end
        default: begin
          state_nx = IDLE;
          count_nx = '0;
        end
      endcase
    end
  end

  assign bus.Period    = period_q;
  assign bus.High_Time = high_q;
  assign bus.Low_Time  = low_q;
  assign bus.Valid     = valid_q;
  assign bus.Timeout   = timeout_q;
  assign bus.Busy      = (state == MEASURE_HI) || (state == MEASURE_LO);

endmodule
`default_nettype wire

// File: tb/tb_clk_period_meter.sv
`default_nettype none
// ============================================================================
// tb_clk_period_meter : directed, table-driven check of clk_period_meter (width 8)
// Revision 1.0
// ============================================================================
module tb_clk_period_meter;

  localparam int W = 8;

  typedef struct {
    int hi;
    int lo;
    int period;
    int high;
    int low;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   cyc;
  bit   wave_on;
  int   wave_hi;
  int   wave_lo;
  int   phase;
  vec_t vecs [7];

  clk_period_meter_if #(.divisor_width(W)) bus ();

  clk_period_meter #(
    .divisor_width (W),
    .SYNC_STAGES   (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance one clk edge, then drive the ideal BCLK waveform for the next cycle
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (wave_on) begin
      bus.BCLK_in = (phase < wave_hi);
      phase       = (phase + 1 == wave_hi + wave_lo) ? 0 : phase + 1;
    end
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.Valid && n < budget);
    chk(name, int'(bus.Valid), 1);
  endtask

  task automatic start_wave(input int hi, input int lo);
    wave_hi = hi;
    wave_lo = lo;
    phase   = 0;
    wave_on = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_period"},  int'(bus.Period),    0);
    chk({tag, "_high"},    int'(bus.High_Time), 0);
    chk({tag, "_low"},     int'(bus.Low_Time),  0);
    chk({tag, "_valid"},   int'(bus.Valid),     0);
    chk({tag, "_timeout"}, int'(bus.Timeout),   0);
    chk({tag, "_busy"},    int'(bus.Busy),      0);
  endtask

  initial begin
    int nval;
    int last;
    int t0;
    int n;
    int stray;
    bit held;

    vecs[0] = '{hi: 4,   lo: 4,   period: 8,   high: 4,   low: 4};
    vecs[1] = '{hi: 3,   lo: 2,   period: 5,   high: 3,   low: 2};
    vecs[2] = '{hi: 1,   lo: 1,   period: 2,   high: 1,   low: 1};
    vecs[3] = '{hi: 5,   lo: 7,   period: 12,  high: 5,   low: 7};
    vecs[4] = '{hi: 2,   lo: 9,   period: 11,  high: 2,   low: 9};
    vecs[5] = '{hi: 10,  lo: 3,   period: 13,  high: 10,  low: 3};
    vecs[6] = '{hi: 128, lo: 127, period: 255, high: 128, low: 127};

    checks      = 0;
    failures    = 0;
    cyc         = 0;
    wave_on     = 1'b0;
    wave_hi     = 4;
    wave_lo     = 4;
    phase       = 0;
    rst_n       = 1'b0;
    bus.EN      = 1'b0;
    bus.BCLK_in = 1'b0;

    repeat (3) tick();
    check_zero("reset");
    rst_n = 1'b1;
    tick();

    // Table: each vector starts from a clean enable so every Valid must be exact
    for (int v = 0; v < 7; v++) begin
      bus.EN      = 1'b0;
      wave_on     = 1'b0;
      bus.BCLK_in = 1'b0;
      repeat (3) tick();
      start_wave(vecs[v].hi, vecs[v].lo);
      bus.EN = 1'b1;
      nval   = 0;
      last   = -1;
      for (int c = 0; c < (vecs[v].hi + vecs[v].lo) * 5 + 12; c++) begin
        tick();
        if (bus.Valid) begin
          chk($sformatf("v%0d_period", v), int'(bus.Period),    vecs[v].period);
          chk($sformatf("v%0d_high",   v), int'(bus.High_Time), vecs[v].high);
          chk($sformatf("v%0d_low",    v), int'(bus.Low_Time),  vecs[v].low);
          chk($sformatf("v%0d_busy",   v), int'(bus.Busy),      1);
          if (last >= 0) chk($sformatf("v%0d_spacing", v), cyc - last, vecs[v].period);
          last = cyc;
          nval++;
        end
      end
      chk($sformatf("v%0d_enough_valids", v), int'(nval >= 4), 1);
    end

    // Timeout: one rise, then BCLK stuck high
    bus.EN      = 1'b0;
    wave_on     = 1'b0;
    bus.BCLK_in = 1'b0;
    repeat (3) tick();
    bus.EN = 1'b1;
    repeat (2) tick();
    bus.BCLK_in = 1'b1;
    n = 0;
    while (!bus.Busy && n < 20) begin
      tick();
      n++;
    end
    chk("to_busy_rise", int'(bus.Busy), 1);
    t0    = cyc;
    stray = 0;
    n     = 0;
    while (!bus.Timeout && n < 400) begin
      tick();
      n++;
      if (bus.Valid) stray++;
    end
    // Count 1 on entry reaches 255 after 254 more edges; Timeout lands on the next one
    chk("to_latency",      cyc - t0,           255);
    chk("to_busy_fall",    int'(bus.Busy),     0);
    chk("to_no_valid",     stray,              0);
    chk("to_period_hold",  int'(bus.Period),   255);
    chk("to_high_hold",    int'(bus.High_Time), 128);
    start_wave(4, 4);
    held = 1'b1;
    n    = 0;
    while (!bus.Valid && n < 60) begin
      tick();
      n++;
      if (!bus.Valid && !bus.Timeout) held = 1'b0;
    end
    chk("to_sticky",        int'(held),        1);
    chk("to_recover_valid", int'(bus.Valid),   1);
    chk("to_clear",         int'(bus.Timeout), 0);
    chk("to_recover_per",   int'(bus.Period),  8);

    // EN drop mid MEASURE_LO
    wait_valid("en_first_valid", 40);
    repeat (5) tick();
    chk("en_busy_before", int'(bus.Busy), 1);
    bus.EN = 1'b0;
    stray  = 0;
    repeat (3) begin
      tick();
      if (bus.Valid) stray++;
    end
    chk("en_no_valid",   stray,               0);
    chk("en_busy",       int'(bus.Busy),      0);
    chk("en_timeout",    int'(bus.Timeout),   0);
    chk("en_hold_per",   int'(bus.Period),    8);
    chk("en_hold_low",   int'(bus.Low_Time),  4);
    bus.EN = 1'b1;
    t0     = cyc;
    wait_valid("en_resume_valid", 40);
    chk("en_full_period", int'(cyc - t0 >= 9), 1);
    chk("en_resume_per",  int'(bus.Period),    8);
    chk("en_resume_high", int'(bus.High_Time), 4);

    // Rate change 8 -> 12: the first Valid after the switch may be mixed
    wait_valid("rate_pre_valid", 40);
    start_wave(6, 6);
    for (int k = 0; k < 5; k++) begin
      wait_valid($sformatf("rate_valid%0d", k), 60);
      if (k > 0) chk($sformatf("rate_period%0d", k), int'(bus.Period), 12);
    end
    chk("rate_high", int'(bus.High_Time), 6);

    // Reset in MEASURE_HI clears outputs without waiting for a clock edge
    start_wave(4, 4);
    wait_valid("rst_pre_valid", 40);
    repeat (2) tick();
    chk("rst_busy_before", int'(bus.Busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("rst_async");
    tick();
    rst_n = 1'b1;
    start_wave(4, 4);
    for (int k = 0; k < 3; k++) begin
      wait_valid($sformatf("rst_valid%0d", k), 40);
      chk($sformatf("rst_period%0d", k), int'(bus.Period),    8);
      chk($sformatf("rst_high%0d",   k), int'(bus.High_Time), 4);
      chk($sformatf("rst_low%0d",    k), int'(bus.Low_Time),  4);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
